// File: rtl/fmdsp_pkg.sv
// Shared FMDSP definitions: normalizer state encoding and shift-range helper.
package fmdsp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int max_shift(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/sign_run_detect.sv
// Flags when the top 2^k+1 bits of a word are all copies of its sign bit.
module sign_run_detect
    import fmdsp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHIFT_BITS = 3
) (
    input  logic [WIDTH-1:0]      cur,
    input  logic [SHIFT_BITS-1:0] k,
    output logic                  run_eq
);

    int span;

    always_comb begin
        span   = 1 << k;
        // A span reaching past the last legal shift position can never be applied.
        run_eq = (span <= max_shift(WIDTH));
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (i < span && cur[WIDTH-2-i] != cur[WIDTH-1]) begin
                run_eq = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sign_normalizer.sv
// Finds the left shift that strips redundant sign bits, via a binary search
// over power-of-two shift steps (largest first), one step per cycle.
module sign_normalizer
    import fmdsp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHIFT_BITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] data_out,
    output logic [SHIFT_BITS-1:0]   shift_out,
    output logic                    zero_out
);

    state_t                  state;
    state_t                  state_next;
    logic signed [WIDTH-1:0] cur;
    logic [SHIFT_BITS-1:0]   count;
    logic [SHIFT_BITS-1:0]   step;
    logic                    zero;
    logic                    run_eq;
    logic [SHIFT_BITS-1:0]   shift_amt;

    assign shift_amt = SHIFT_BITS'(1) << step;

    sign_run_detect #(
        .WIDTH      (WIDTH),
        .SHIFT_BITS (SHIFT_BITS)
    ) u_run_detect (
        .cur    (cur),
        .k      (step),
        .run_eq (run_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SCAN;
            SCAN:    if (step == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur   <= '0;
            count <= '0;
            step  <= '0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur   <= data_in;
                        count <= '0;
                        step  <= SHIFT_BITS'(SHIFT_BITS - 1);
                        zero  <= (data_in == '0);
                    end
                end
                SCAN: begin
                    if (run_eq) begin
                        cur   <= cur << shift_amt;
                        count <= count + shift_amt;
                    end
                    if (step != '0) begin
                        step <= step - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A zero operand runs the full scan for fixed latency; its result is masked here.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        data_out  = '0;
        shift_out = '0;
        zero_out  = 1'b0;
        if (state == DONE) begin
            zero_out = zero;
            if (!zero) begin
                data_out  = cur;
                shift_out = count;
            end
        end
    end

endmodule

// File: tb/tb_sign_normalizer.sv
// Directed and randomized checks of sign_normalizer at WIDTH=8, SHIFT_BITS=3.
module tb_sign_normalizer;

    localparam int WIDTH      = 8;
    localparam int SHIFT_BITS = 3;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      data_out;
    logic [SHIFT_BITS-1:0] shift_out;
    logic                  zero_out;

    int checks = 0;
    int errors = 0;

    sign_normalizer #(
        .WIDTH      (WIDTH),
        .SHIFT_BITS (SHIFT_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .shift_out (shift_out),
        .zero_out  (zero_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand with out_ready high and check latency, result and return to IDLE.
    task automatic run_op(input string tag, input logic [7:0] din,
                          input logic [7:0] exp_d, input logic [2:0] exp_s, input logic exp_z);
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = din;
        tick();
        in_valid  = 1'b0;
        data_in   = 8'hA5;
        tick();
        chk({tag, ".busy1"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, ".busy2"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, ".vld"},   32'(out_valid), 32'd1);
        chk({tag, ".data"},  32'(data_out),  32'(exp_d));
        chk({tag, ".shift"}, 32'(shift_out), 32'(exp_s));
        chk({tag, ".zero"},  32'(zero_out),  32'(exp_z));
        tick();
        chk({tag, ".idle_vld"}, 32'(out_valid), 32'd0);
        chk({tag, ".idle_rdy"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] r;
        logic [7:0] shl;
        int         s;

        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset.rdy",   32'(in_ready),  32'd1);
        chk("reset.vld",   32'(out_valid), 32'd0);
        chk("reset.data",  32'(data_out),  32'd0);
        chk("reset.shift", 32'(shift_out), 32'd0);
        chk("reset.zero",  32'(zero_out),  32'd0);

        run_op("x03", 8'h03, 8'h60, 3'd5, 1'b0);
        run_op("xF8", 8'hF8, 8'h80, 3'd4, 1'b0);
        run_op("x40", 8'h40, 8'h40, 3'd0, 1'b0);
        run_op("x80", 8'h80, 8'h80, 3'd0, 1'b0);
        run_op("xFF", 8'hFF, 8'h80, 3'd7, 1'b0);
        run_op("x00", 8'h00, 8'h00, 3'd0, 1'b1);

        // Backpressure: result held while out_ready is low, new operands ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 8'h05;
        tick();
        data_in   = 8'h7F;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp.vld",   32'(out_valid), 32'd1);
            chk("bp.data",  32'(data_out),  32'h50);
            chk("bp.shift", 32'(shift_out), 32'd4);
            chk("bp.rdy",   32'(in_ready),  32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp.release_vld", 32'(out_valid), 32'd1);
        tick();
        chk("bp.after_vld", 32'(out_valid), 32'd0);
        chk("bp.after_rdy", 32'(in_ready),  32'd1);
        tick();
        chk("bp.stay_idle", 32'(out_valid), 32'd0);

        // Reset during SCAN discards the operation.
        in_valid = 1'b1;
        data_in  = 8'h01;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst.rdy",   32'(in_ready),  32'd1);
        chk("rst.vld",   32'(out_valid), 32'd0);
        chk("rst.data",  32'(data_out),  32'd0);
        chk("rst.shift", 32'(shift_out), 32'd0);
        chk("rst.zero",  32'(zero_out),  32'd0);
        tick();
        chk("rst.no_resume", 32'(out_valid), 32'd0);
        run_op("x01", 8'h01, 8'h40, 3'd6, 1'b0);

        // Random operands against a one-bit-at-a-time reference.
        for (int n = 0; n < 1000; n++) begin
            r = 8'($urandom);
            v = r;
            s = 0;
            while (s < WIDTH - 1 && v[7] == v[6]) begin
                v = v << 1;
                s++;
            end
            if (r == 8'h00) begin
                v = 8'h00;
                s = 0;
            end
            run_op("rand", r, v, 3'(s), (r == 8'h00));
            tick();
            // Result from run_op is gone; recheck the invariants on a fresh pass.
            in_valid = 1'b1;
            data_in  = r;
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            tick();
            shl = r << shift_out;
            chk("rand.shl", 32'(data_out), 32'(r == 8'h00 ? 8'h00 : shl));
            if (r != 8'h00) begin
                chk("rand.norm", 32'(data_out[7] ^ data_out[6]), 32'd1);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
